cmplt_arbiter: RTL and testbench

//  Completion collector feeding the reorder buffer's completion port. Accepts ROB tags from NUM_SRC

---
 rtl/cmplt_pkg.sv | 28 ++
 rtl/cmplt_src_fifo.sv | 90 +++++++++
 rtl/cmplt_arbiter.sv | 159 +++++++++++++++
 tb/tb_cmplt_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplt_pkg.sv
// -----------------------------------------------------------------------------
// cmplt_pkg
//   Shared constants for the completion path. Used by the completion arbiter,
//   the reorder buffer and the functional-unit wrappers so that all of them
//   agree on the completion port width and the default ROB tag width.
//
//   CMPLT_OUT_WIDTH : tags delivered to the ROB per cycle
//   CMPLT_TAG_WIDTH : default ROB tag width ($clog2(15+1)+1 for a 15-entry ROB)
//   cmplt_wrap_inc  : modulo increment used for FIFO and round-robin pointers
// -----------------------------------------------------------------------------
package cmplt_pkg;

    localparam int CMPLT_OUT_WIDTH = 3;
    localparam int CMPLT_TAG_WIDTH = 5;

    // Increment value and wrap to 0 when it reaches modulus.
    function automatic int cmplt_wrap_inc(input int value, input int modulus);
        int next_v;
        next_v = value + 1;
        if (next_v >= modulus) begin
            next_v = 0;
        end else begin
            next_v = next_v;
        end
        return next_v;
    endfunction

endpackage

// File: rtl/cmplt_src_fifo.sv
// -----------------------------------------------------------------------------
// cmplt_src_fifo
//   Small per-source completion FIFO. One instance per functional unit.
//
//   clk        : clock
//   rst        : synchronous reset, active low
//   push_i     : write push_tag_i (ignored while full)
//   push_tag_i : tag to store
//   pop_i      : drop the current head (ignored while empty)
//   head_o     : oldest stored tag, meaningful only when empty_o is 0
//   empty_o    : no tag stored
//   full_o     : SRC_DEPTH tags stored; comes from the registered count only
// -----------------------------------------------------------------------------
module cmplt_src_fifo
    import cmplt_pkg::*;
#(
    parameter int TAG_WIDTH = CMPLT_TAG_WIDTH,
    parameter int SRC_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [TAG_WIDTH-1:0] push_tag_i,
    input  logic                 pop_i,
    output logic [TAG_WIDTH-1:0] head_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int PTR_W = (SRC_DEPTH > 1) ? $clog2(SRC_DEPTH) : 1;
    localparam int CNT_W = $clog2(SRC_DEPTH + 1);

    logic [TAG_WIDTH-1:0] mem_q [SRC_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full_o    = (count_q == CNT_W'(SRC_DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Next pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = PTR_W'(cmplt_wrap_inc(int'(wr_ptr_q), SRC_DEPTH));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = PTR_W'(cmplt_wrap_inc(int'(rd_ptr_q), SRC_DEPTH));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < SRC_DEPTH; i++) begin
                mem_q[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_tag_i;
            end
        end
    end

endmodule

// File: rtl/cmplt_arbiter.sv
// -----------------------------------------------------------------------------
// cmplt_arbiter
//   Collects ROB completion tags from NUM_SRC functional units, buffers them
//   per source and hands up to CMPLT_OUT_WIDTH tags per cycle to the ROB.
//   Sources are scanned round-robin starting at rr_ptr; the pointer moves to
//   one past the last source served so every source gets its turn.
//
//   clk              : clock
//   rst              : synchronous reset, active low
//   src_tag          : tag of source i at [i*TAG_WIDTH +: TAG_WIDTH]
//   src_valid        : source i presents a tag
//   src_ready        : FIFO i has room (registered occupancy only)
//   completed        : registered tags to the ROB, slot j at [j*TAG_WIDTH +: TAG_WIDTH]
//   cmplt_valid      : registered slot valids, always LSB-contiguous
//   perf_full_cycles : saturating count of cycles with any source not ready
//                      (present only when CMPLT_PERF_EN is defined)
//
//   Build option: define CMPLT_PERF_EN to add the perf_full_cycles counter.
// -----------------------------------------------------------------------------
module cmplt_arbiter
    import cmplt_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int TAG_WIDTH = CMPLT_TAG_WIDTH,
    parameter int SRC_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [TAG_WIDTH*NUM_SRC-1:0]         src_tag,
    input  logic [NUM_SRC-1:0]                   src_valid,
    output logic [NUM_SRC-1:0]                   src_ready,
    output logic [TAG_WIDTH*CMPLT_OUT_WIDTH-1:0] completed,
    output logic [CMPLT_OUT_WIDTH-1:0]           cmplt_valid
`ifdef CMPLT_PERF_EN
    ,
    output logic [15:0]                          perf_full_cycles
`endif
);

    localparam int RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SLOT_W = $clog2(CMPLT_OUT_WIDTH + 1);

    logic [NUM_SRC-1:0]                   push_s;
    logic [NUM_SRC-1:0]                   pop_s;
    logic [NUM_SRC-1:0]                   empty_s;
    logic [NUM_SRC-1:0]                   full_s;
    logic [TAG_WIDTH-1:0]                 head_s [NUM_SRC];
    logic [TAG_WIDTH-1:0]                 slot_tag_s [CMPLT_OUT_WIDTH];
    logic [RR_W-1:0]                      rr_ptr_q;
    logic [RR_W-1:0]                      rr_ptr_d;
    logic [TAG_WIDTH*CMPLT_OUT_WIDTH-1:0] completed_q;
    logic [TAG_WIDTH*CMPLT_OUT_WIDTH-1:0] completed_d;
    logic [CMPLT_OUT_WIDTH-1:0]           cmplt_valid_q;
    logic [CMPLT_OUT_WIDTH-1:0]           cmplt_valid_d;

    // Ready looks only at registered occupancy, so a full FIFO stays not-ready
    // even in a cycle where its head is being popped.
    assign src_ready = ~full_s;
    assign push_s    = src_valid & src_ready;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        cmplt_src_fifo #(
            .TAG_WIDTH (TAG_WIDTH),
            .SRC_DEPTH (SRC_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (push_s[g]),
            .push_tag_i (src_tag[g*TAG_WIDTH +: TAG_WIDTH]),
            .pop_i      (pop_s[g]),
            .head_o     (head_s[g]),
            .empty_o    (empty_s[g]),
            .full_o     (full_s[g])
        );
    end

    // Round-robin scan of FIFO heads: the k-th non-empty source found goes to slot k.
    always_comb begin : select_proc
        int                src_int;
        logic [RR_W-1:0]   src_idx;
        logic [SLOT_W-1:0] n_taken;
        pop_s         = {NUM_SRC{1'b0}};
        cmplt_valid_d = {CMPLT_OUT_WIDTH{1'b0}};
        rr_ptr_d      = rr_ptr_q;
        n_taken       = {SLOT_W{1'b0}};
        src_int       = 0;
        src_idx       = {RR_W{1'b0}};
        for (int j = 0; j < CMPLT_OUT_WIDTH; j++) begin
            slot_tag_s[j] = {TAG_WIDTH{1'b0}};
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            src_int = int'(rr_ptr_q) + k;
            if (src_int >= NUM_SRC) begin
                src_int = src_int - NUM_SRC;
            end else begin
                src_int = src_int;
            end
            src_idx = RR_W'(src_int);
            if (!empty_s[src_idx] && (n_taken < SLOT_W'(CMPLT_OUT_WIDTH))) begin
                pop_s[src_idx]         = 1'b1;
                slot_tag_s[n_taken]    = head_s[src_idx];
                cmplt_valid_d[n_taken] = 1'b1;
                // Last assignment wins, leaving the pointer one past the last source served.
                rr_ptr_d = RR_W'(cmplt_wrap_inc(src_int, NUM_SRC));
                n_taken  = n_taken + SLOT_W'(1);
            end else begin
                n_taken = n_taken;
            end
        end
    end

    for (genvar j = 0; j < CMPLT_OUT_WIDTH; j++) begin : g_slot
        assign completed_d[j*TAG_WIDTH +: TAG_WIDTH] = slot_tag_s[j];
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= {RR_W{1'b0}};
            completed_q   <= {(TAG_WIDTH*CMPLT_OUT_WIDTH){1'b0}};
            cmplt_valid_q <= {CMPLT_OUT_WIDTH{1'b0}};
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            completed_q   <= completed_d;
            cmplt_valid_q <= cmplt_valid_d;
        end
    end

    assign completed   = completed_q;
    assign cmplt_valid = cmplt_valid_q;

`ifdef CMPLT_PERF_EN
    logic [15:0] perf_q;
    logic [15:0] perf_d;

    // Count cycles in which any source is being held off, saturating at all ones.
    always_comb begin
        if ((&src_ready) || (perf_q == 16'hFFFF)) begin
            perf_d = perf_q;
        end else begin
            perf_d = perf_q + 16'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_full_cycles = perf_q;
`else
    // No performance counter in this build.
`endif

endmodule

// File: tb/tb_cmplt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmplt_arbiter
//   Directed bench for cmplt_arbiter. A queue-based model of the collector is
//   advanced once per cycle and compared against the DUT on every falling
//   edge; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_cmplt_arbiter;

    localparam int NS    = 4;
    localparam int TW    = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW*NS-1:0] src_tag;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [TW*3-1:0] completed;
    logic [2:0]      cmplt_valid;
`ifdef CMPLT_PERF_EN
    logic [15:0]     perf_full_cycles;
`endif

    cmplt_arbiter #(
        .NUM_SRC   (NS),
        .TAG_WIDTH (TW),
        .SRC_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_tag     (src_tag),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .completed   (completed),
        .cmplt_valid (cmplt_valid)
`ifdef CMPLT_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [TW-1:0] mq [NS][$];
    int            m_rr;
    logic [2:0]    m_valid;
    logic [TW-1:0] m_slot [3];
    int            m_perf;
    bit            m_known = 1'b0;

    // scenario monitors
    bit            collect_src0 = 1'b0;
    logic [TW-1:0] src0_seen [$];
    bit            fair_win = 1'b0;
    int            fair_cnt [NS];
    bit            watch_old = 1'b0;
    int            old_seen = 0;

    task automatic model_step();
        int         taken;
        int         next_rr;
        int         s;
        bit         any_full;
        bit         rdy [NS];
        if (!rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr    = 0;
            m_valid = 3'b000;
            for (int j = 0; j < 3; j++) m_slot[j] = '0;
            m_perf  = 0;
            m_known = 1'b1;
        end else begin
            taken    = 0;
            next_rr  = m_rr;
            any_full = 1'b0;
            for (int j = 0; j < 3; j++) m_slot[j] = '0;
            for (int i = 0; i < NS; i++) begin
                rdy[i] = (mq[i].size() < DEPTH);
                if (!rdy[i]) any_full = 1'b1;
            end
            for (int k = 0; k < NS; k++) begin
                s = (m_rr + k) % NS;
                if (mq[s].size() > 0 && taken < 3) begin
                    m_slot[taken] = mq[s].pop_front();
                    taken++;
                    next_rr = (s + 1) % NS;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && rdy[i]) mq[i].push_back(src_tag[i*TW +: TW]);
            end
            m_rr    = next_rr;
            m_valid = (taken == 0) ? 3'b000 : (taken == 1) ? 3'b001 : (taken == 2) ? 3'b011 : 3'b111;
            if (any_full && m_perf < 65535) m_perf++;
        end
    endtask

    // Compare process: check DUT against the model, then advance the model.
    initial begin
        logic [NS-1:0] exp_rdy;
        logic [TW-1:0] t;
        forever begin
            @(negedge clk);
            if (m_known) begin
                for (int i = 0; i < NS; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
                check("cmplt_valid", {29'd0, cmplt_valid}, {29'd0, m_valid});
                check("completed", {17'd0, completed}, {17'd0, m_slot[2], m_slot[1], m_slot[0]});
                check("src_ready", {28'd0, src_ready}, {28'd0, exp_rdy});
`ifdef CMPLT_PERF_EN
                check("perf_full_cycles", {16'd0, perf_full_cycles}, m_perf);
`endif
                for (int j = 0; j < 3; j++) begin
                    if (cmplt_valid[j]) begin
                        t = completed[j*TW +: TW];
                        if (collect_src0 && t >= 5'd10) src0_seen.push_back(t);
                        if (fair_win) fair_cnt[int'(t) % NS]++;
                        if (watch_old && t >= 5'd16) old_seen++;
                    end
                end
            end
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0;
        src_tag   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        int  seq;
        int  cnt [NS];
        bit  saw_low;
        bit  r;
        logic [NS-1:0] rv;

        // 1. reset with all sources valid
        rst       = 1'b0;
        src_valid = 4'b1111;
        src_tag   = {5'd4, 5'd3, 5'd2, 5'd1};
        cyc();
        cyc();
        #2;
        check("reset_valid", {29'd0, cmplt_valid}, 32'd0);
        check("reset_completed", {17'd0, completed}, 32'd0);
        check("reset_ready", {28'd0, src_ready}, 32'hF);
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        #2;
        check("reset_nothing_accepted", {29'd0, cmplt_valid}, 32'd0);

        // 2. single tag from source 2, two-cycle latency
        src_valid = 4'b0100;
        src_tag[2*TW +: TW] = 5'd9;
        cyc();
        idle();
        cyc();
        #2;
        check("single_valid", {29'd0, cmplt_valid}, 32'd1);
        check("single_tag", {17'd0, completed}, 32'd9);
        cyc();
        #2;
        check("single_after", {29'd0, cmplt_valid}, 32'd0);

        // 3. burst from all sources with rr_ptr=0
        do_reset();
        src_valid = 4'b1111;
        src_tag   = {5'd4, 5'd3, 5'd2, 5'd1};
        cyc();
        idle();
        cyc();
        #2;
        check("burst1_valid", {29'd0, cmplt_valid}, 32'd7);
        check("burst1_tags", {17'd0, completed}, {17'd0, 5'd3, 5'd2, 5'd1});
        cyc();
        #2;
        check("burst2_valid", {29'd0, cmplt_valid}, 32'd1);
        check("burst2_tags", {17'd0, completed}, 32'd4);
        // rr_ptr should be back at 0: a second burst starts at source 0 again
        src_valid = 4'b1111;
        src_tag   = {5'd8, 5'd7, 5'd6, 5'd5};
        cyc();
        idle();
        cyc();
        #2;
        check("rr_pin_valid", {29'd0, cmplt_valid}, 32'd7);
        check("rr_pin_tags", {17'd0, completed}, {17'd0, 5'd7, 5'd6, 5'd5});
        cyc();
        #2;
        check("rr_pin_tail", {17'd0, completed}, 32'd8);

        // 4. backpressure on saturated sources
        do_reset();
        collect_src0 = 1'b1;
        seq     = 10;
        saw_low = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src_valid = 4'b1111;
            src_tag   = {5'd3, 5'd2, 5'd1, 5'(seq)};
            r = src_ready[0];
            if (!r) saw_low = 1'b1;
            cyc();
            if (r) seq++;
        end
        idle();
        repeat (6) cyc();
        collect_src0 = 1'b0;
        check("bp_ready_dropped", {31'd0, saw_low}, 32'd1);
        check("bp_src0_count", src0_seen.size(), seq - 10);
        for (int i = 0; i < src0_seen.size(); i++) begin
            check("bp_src0_order", {27'd0, src0_seen[i]}, 10 + i);
        end

        // 5. fairness with all sources continuously valid
        do_reset();
        for (int s = 0; s < NS; s++) begin
            cnt[s]      = 0;
            fair_cnt[s] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            src_valid = 4'b1111;
            for (int s = 0; s < NS; s++) src_tag[s*TW +: TW] = 5'(s + 4 * (cnt[s] % 8));
            rv = src_ready;
            if (i == 3) fair_win = 1'b1;
            if (i == 15) fair_win = 1'b0;
            cyc();
            for (int s = 0; s < NS; s++) if (rv[s]) cnt[s]++;
        end
        idle();
        repeat (4) cyc();
        for (int s = 0; s < NS; s++) begin
            check("fair_grants_in_range", {31'd0, (fair_cnt[s] >= 8 && fair_cnt[s] <= 10)}, 32'd1);
        end
        check("fair_total", fair_cnt[0] + fair_cnt[1] + fair_cnt[2] + fair_cnt[3], 32'd36);

        // 6. reset in the middle of traffic
        do_reset();
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        for (int i = 0; i < 3; i++) begin
            src_valid = 4'b1111;
            for (int s = 0; s < NS; s++) src_tag[s*TW +: TW] = 5'(16 + 4 * cnt[s] + s);
            rv = src_ready;
            cyc();
            for (int s = 0; s < NS; s++) if (rv[s]) cnt[s]++;
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        idle();
        watch_old = 1'b1;
        #2;
        check("midrst_valid0", {29'd0, cmplt_valid}, 32'd0);
        check("midrst_completed0", {17'd0, completed}, 32'd0);
`ifdef CMPLT_PERF_EN
        check("midrst_perf", {16'd0, perf_full_cycles}, 32'd0);
`endif
        for (int i = 1; i < 4; i++) begin
            cyc();
            #2;
            check("midrst_valid", {29'd0, cmplt_valid}, 32'd0);
        end
        src_valid = 4'b0010;
        src_tag[1*TW +: TW] = 5'd5;
        cyc();
        idle();
        cyc();
        #2;
        check("midrst_fresh_valid", {29'd0, cmplt_valid}, 32'd1);
        check("midrst_fresh_tag", {17'd0, completed}, 32'd5);
        repeat (3) cyc();
        watch_old = 1'b0;
        check("midrst_no_old_tags", old_seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
